uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmit FIFO write port between NREQ independent byte-stream requesters. Once granted, a requester holds the port for a whole message, terminated by its `last` flag or by an idle timeout. An optional channel tag byte can be emitted at the start of each message. The block sits between on-chip message sources (debug console, trace, firmware printf engines) and the TX FIFO write side of the APB UART; it drives that FIFO's `wr`/`w_data` and watches its `full` flag.

---
 rtl/uart_tx_sched.sv | 126 ++++++++++++
 tb/tb_uart_tx_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART TX FIFO write port between byte-stream requesters
// A granted requester owns the port for a whole message; an optional tag byte precedes each message.
module uart_tx_sched #(
  parameter int          NREQ     = 4,
  parameter int          TAG_EN   = 1,
  parameter logic [7:0]  TAG_BASE = 8'hF0,
  parameter int          TIMEOUT  = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        fifo_wdata,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              abort
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          abort_q, abort_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          cur_valid;
  logic          cur_last;

  // Scan downward so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign cur_valid = req_valid[gidx_q];
  assign cur_last  = req_last[gidx_q];

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    abort_d    = 1'b0;
    fifo_wr    = 1'b0;
    fifo_wdata = 8'h00;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (pick_valid) begin
          gidx_d   = pick_idx;
          rr_ptr_d = IW'((int'(pick_idx) + 1) % NREQ);
          state_d  = (TAG_EN != 0) ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        fifo_wdata = TAG_BASE + 8'(gidx_q);
        fifo_wr    = ~fifo_full;
        if (!fifo_full) state_d = S_DATA;
      end
      S_DATA: begin
        fifo_wdata        = req_data[{gidx_q, 3'b000} +: 8];
        fifo_wr           = cur_valid & ~fifo_full;
        req_ready[gidx_q] = cur_valid & ~fifo_full;
        if (cur_valid && !fifo_full && cur_last) state_d = S_IDLE;
        // A stalled-but-valid owner is not idle: backpressure never times out.
        if (TIMEOUT != 0) begin
          if (cur_valid) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == TO_VAL) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q != S_IDLE) grant[gidx_q] = 1'b1;
  end

  assign busy  = (state_q != S_IDLE);
  assign abort = abort_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic [7:0]  fifo_wdata;
  logic        fifo_wr, fifo_full, busy, abort;

  logic [3:0]  b_valid, b_last, b_ready, b_grant;
  logic [31:0] b_data;
  logic [7:0]  b_wdata;
  logic        b_wr, b_full, b_busy, b_abort;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(4), .TAG_EN(1), .TAG_BASE(8'hF0), .TIMEOUT(4)) dut (
    .PCLK(clk), .PRESET(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wdata(fifo_wdata),
    .fifo_wr(fifo_wr), .fifo_full(fifo_full), .grant(grant), .busy(busy), .abort(abort));

  uart_tx_sched #(.NREQ(4), .TAG_EN(0), .TAG_BASE(8'hF0), .TIMEOUT(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .req_valid(b_valid), .req_data(b_data),
    .req_last(b_last), .req_ready(b_ready), .fifo_wdata(b_wdata),
    .fifo_wr(b_wr), .fifo_full(b_full), .grant(b_grant), .busy(b_busy), .abort(b_abort));

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] bq [4][$];
  logic [3:0] en, gap_prev;
  int         gap_pct, full_from, full_to, idx, abort_cnt, ready_viol;
  bit         full_rand;

  logic       obs_wr [64], obs_busy [64], obs_abort [64];
  logic [7:0] obs_data [64];
  logic [3:0] obs_grant [64], obs_ready [64];
  logic       e_wr [64];
  logic [7:0] e_data [64];
  logic [3:0] e_grant [64];
  logic [7:0] got [$];

  task automatic step();
    logic g;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      g = 1'b0;
      if (en[i] && bq[i].size() > 0) begin
        g = 1'b1;
        if (grant[i] && !gap_prev[i] && ($urandom_range(99) < gap_pct)) g = 1'b0;
      end
      gap_prev[i] = en[i] && (bq[i].size() > 0) && !g;
      req_valid[i] = g;
      if (bq[i].size() > 0) begin
        req_data[8*i +: 8] = bq[i][0][7:0];
        req_last[i]        = bq[i][0][8];
      end else begin
        req_last[i] = 1'b0;
      end
    end
    fifo_full = full_rand ? ($urandom_range(3) == 0) : (idx >= full_from && idx < full_to);
    @(negedge clk);
    if (idx < 64) begin
      obs_wr[idx] = fifo_wr;       obs_data[idx]  = fifo_wdata;
      obs_grant[idx] = grant;      obs_ready[idx] = req_ready;
      obs_busy[idx] = busy;        obs_abort[idx] = abort;
    end
    if (fifo_wr) got.push_back(fifo_wdata);
    if (abort) abort_cnt++;
    if ((req_ready & ~grant) != 4'b0 || (req_ready & ~req_valid) != 4'b0) ready_viol++;
    for (int i = 0; i < 4; i++)
      if (req_ready[i] && req_valid[i]) void'(bq[i].pop_front());
    idx++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) bq[i].delete();
    en = 4'b0; gap_prev = 4'b0; gap_pct = 0; full_rand = 0; full_from = 0; full_to = 0;
    req_valid = 4'b0; req_last = 4'b0; req_data = 32'h0; fifo_full = 1'b0;
    b_valid = 4'b0; b_last = 4'b0; b_data = 32'h0; b_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idx = 0; got.delete(); abort_cnt = 0; ready_viol = 0;
    for (int c = 0; c < 64; c++) begin e_wr[c] = 1'b0; e_data[c] = 8'h00; e_grant[c] = 4'b0; end
  endtask

  task automatic push_msg(input int r, input logic [7:0] b [$]);
    for (int k = 0; k < b.size(); k++) bq[r].push_back({(k == b.size() - 1), b[k]});
  endtask

  // Expected schedule of an unstalled message whose tag lands in cycle c0.
  task automatic exp_msg(input int c0, input int r, input logic [7:0] b [$]);
    e_wr[c0] = 1'b1; e_data[c0] = 8'hF0 + 8'(r); e_grant[c0] = 4'(1 << r);
    for (int k = 0; k < b.size(); k++) begin
      e_wr[c0+1+k] = 1'b1; e_data[c0+1+k] = b[k]; e_grant[c0+1+k] = 4'(1 << r);
    end
  endtask

  function automatic logic [7:0] rb();
    return 8'($urandom_range(255));
  endfunction

  task automatic test_reset();
    req_valid = 4'hF; b_valid = 4'hF; req_last = 4'hF; b_last = 4'hF;
    #3;
    n_checks++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_wr got=%b exp=0", fifo_wr); end
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_checks++; if (busy !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL reset_busy_abort got=%b%b exp=00", busy, abort); end
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    n_checks++; if (b_wr !== 1'b0 || b_grant !== 4'b0) begin n_fail++; $display("FAIL reset_notag got=%b/%b exp=0/0000", b_wr, b_grant); end
    reset_dut();
  endtask

  task automatic test_single();
    logic [7:0] m [$];
    reset_dut();
    m = '{8'h41, 8'h42, 8'h43};
    en = 4'b0100; push_msg(2, m); exp_msg(1, 2, m);
    repeat (7) step();
    for (int c = 0; c < 7; c++) begin
      n_checks++; if (obs_wr[c] !== e_wr[c] || (e_wr[c] && obs_data[c] !== e_data[c]))
        begin n_fail++; $display("FAIL single_write c=%0d got=%b/%h exp=%b/%h", c, obs_wr[c], obs_data[c], e_wr[c], e_data[c]); end
      n_checks++; if (obs_grant[c] !== e_grant[c]) begin n_fail++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, obs_grant[c], e_grant[c]); end
      n_checks++; if (obs_ready[c] !== ((c >= 2 && c <= 4) ? 4'b0100 : 4'b0)) begin n_fail++; $display("FAIL single_ready c=%0d got=%b", c, obs_ready[c]); end
    end
    n_checks++; if (obs_busy[4] !== 1'b1 || obs_busy[5] !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop got=%b%b exp=10", obs_busy[4], obs_busy[5]); end
  endtask

  task automatic test_contention();
    logic [7:0] m0 [$], m1 [$], m3 [$], m3b [$], n0 [$];
    reset_dut();
    m0 = '{rb(), rb()}; m1 = '{rb(), rb()}; m3 = '{rb(), rb()}; m3b = '{rb(), rb()}; n0 = '{rb(), rb()};
    en = 4'b1011;
    push_msg(0, m0); push_msg(1, m1); push_msg(3, m3); push_msg(3, m3b);
    exp_msg(1, 0, m0); exp_msg(5, 1, m1); exp_msg(9, 3, m3); exp_msg(13, 0, n0); exp_msg(17, 3, m3b);
    repeat (9) step();
    push_msg(0, n0);
    repeat (12) step();
    for (int c = 0; c < 21; c++) begin
      n_checks++; if (obs_wr[c] !== e_wr[c] || (e_wr[c] && obs_data[c] !== e_data[c]))
        begin n_fail++; $display("FAIL contention_write c=%0d got=%b/%h exp=%b/%h", c, obs_wr[c], obs_data[c], e_wr[c], e_data[c]); end
      n_checks++; if (obs_grant[c] !== e_grant[c]) begin n_fail++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, obs_grant[c], e_grant[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] m [$];
    reset_dut();
    m = '{rb(), rb(), rb(), rb(), rb()};
    en = 4'b0010; push_msg(1, m); full_from = 4; full_to = 14;
    repeat (18) step();
    for (int c = 4; c < 14; c++) begin
      n_checks++; if (obs_wr[c] !== 1'b0 || obs_ready[c] !== 4'b0 || obs_abort[c] !== 1'b0 || obs_busy[c] !== 1'b1)
        begin n_fail++; $display("FAIL bp_stall c=%0d got wr=%b rdy=%b ab=%b busy=%b exp 0/0000/0/1", c, obs_wr[c], obs_ready[c], obs_abort[c], obs_busy[c]); end
      n_checks++; if (obs_data[c] !== m[2]) begin n_fail++; $display("FAIL bp_held c=%0d got=%h exp=%h", c, obs_data[c], m[2]); end
    end
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      n_checks++; if (got[k] !== ((k == 0) ? 8'hF1 : m[k-1])) begin n_fail++; $display("FAIL bp_stream k=%0d got=%h", k, got[k]); end
    end
    n_checks++; if (obs_wr[14] !== 1'b1 || obs_data[14] !== m[2] || obs_busy[17] !== 1'b0)
      begin n_fail++; $display("FAIL bp_resume got=%b/%h busy17=%b exp=1/%h busy17=0", obs_wr[14], obs_data[14], obs_busy[17], m[2]); end
    n_checks++; if (abort_cnt != 0) begin n_fail++; $display("FAIL bp_abort got=%0d exp=0", abort_cnt); end
  endtask

  task automatic test_timeout();
    logic [7:0] b0;
    logic [7:0] m1 [$];
    reset_dut();
    b0 = rb(); m1 = '{rb(), rb()};
    en = 4'b0011; bq[0].push_back({1'b0, b0}); push_msg(1, m1);
    repeat (13) step();
    n_checks++; if (obs_wr[2] !== 1'b1 || obs_data[2] !== b0) begin n_fail++; $display("FAIL to_first got=%b/%h exp=1/%h", obs_wr[2], obs_data[2], b0); end
    for (int c = 3; c < 8; c++) begin
      n_checks++; if (obs_abort[c] !== 1'b0 || obs_busy[c] !== 1'b1 || obs_grant[c] !== 4'b0001 || obs_wr[c] !== 1'b0)
        begin n_fail++; $display("FAIL to_wait c=%0d got ab=%b busy=%b g=%b wr=%b", c, obs_abort[c], obs_busy[c], obs_grant[c], obs_wr[c]); end
    end
    n_checks++; if (obs_abort[8] !== 1'b1 || obs_busy[8] !== 1'b0) begin n_fail++; $display("FAIL to_pulse got ab=%b busy=%b exp=1/0", obs_abort[8], obs_busy[8]); end
    n_checks++; if (obs_abort[9] !== 1'b0 || obs_grant[9] !== 4'b0010 || obs_data[9] !== 8'hF1)
      begin n_fail++; $display("FAIL to_handover got ab=%b g=%b d=%h exp=0/0010/f1", obs_abort[9], obs_grant[9], obs_data[9]); end
    n_checks++; if (obs_data[10] !== m1[0] || obs_data[11] !== m1[1] || abort_cnt != 1)
      begin n_fail++; $display("FAIL to_next got=%h %h aborts=%0d exp=%h %h 1", obs_data[10], obs_data[11], abort_cnt, m1[0], m1[1]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m [$], m0 [$], m2 [$];
    reset_dut();
    m = '{rb(), rb(), rb(), rb(), rb(), rb()};
    en = 4'b0010; push_msg(1, m);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (fifo_wr !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || abort !== 1'b0 || req_ready !== 4'b0)
      begin n_fail++; $display("FAIL mid_reset got wr=%b g=%b busy=%b ab=%b rdy=%b exp all 0", fifo_wr, grant, busy, abort, req_ready); end
    reset_dut();
    m0 = '{rb(), rb()}; m2 = '{rb(), rb()};
    en = 4'b0101; push_msg(2, m2); push_msg(0, m0);
    exp_msg(1, 0, m0); exp_msg(5, 2, m2);
    repeat (9) step();
    for (int c = 0; c < 9; c++) begin
      n_checks++; if (obs_grant[c] !== e_grant[c] || obs_wr[c] !== e_wr[c] || (e_wr[c] && obs_data[c] !== e_data[c]))
        begin n_fail++; $display("FAIL after_reset c=%0d got g=%b wr=%b d=%h exp g=%b wr=%b d=%h", c, obs_grant[c], obs_wr[c], obs_data[c], e_grant[c], e_wr[c], e_data[c]); end
    end
    n_checks++; if (abort_cnt != 0) begin n_fail++; $display("FAIL mid_reset_abort got=%0d exp=0", abort_cnt); end
  endtask

  task automatic test_no_tag();
    logic [7:0] x;
    reset_dut();
    x = rb();
    @(posedge clk); #1 b_valid = 4'b0010; b_last = 4'b0010; b_data[15:8] = x;
    @(negedge clk);
    n_checks++; if (b_wr !== 1'b0) begin n_fail++; $display("FAIL notag_c0 got=%b exp=0", b_wr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (b_wr !== 1'b1 || b_wdata !== x || b_ready !== 4'b0010 || b_grant !== 4'b0010)
      begin n_fail++; $display("FAIL notag_c1 got wr=%b d=%h rdy=%b g=%b exp 1/%h/0010/0010", b_wr, b_wdata, b_ready, b_grant, x); end
    @(posedge clk); #1 b_valid = 4'b0; b_last = 4'b0;
    @(negedge clk);
    n_checks++; if (b_wr !== 1'b0 || b_busy !== 1'b0 || b_grant !== 4'b0 || b_abort !== 1'b0)
      begin n_fail++; $display("FAIL notag_c2 got wr=%b busy=%b g=%b ab=%b exp 0/0/0000/0", b_wr, b_busy, b_grant, b_abort); end
  endtask

  task automatic test_random();
    logic [8:0] mq [4][$];
    logic [7:0] ex [$];
    logic [7:0] m [$];
    logic [8:0] w;
    int p, cyc, tot;
    bit found;
    reset_dut();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 3; n++) begin
        m.delete();
        for (int k = 0; k < int'($urandom_range(5, 1)); k++) m.push_back(rb());
        push_msg(i, m);
      end
    for (int i = 0; i < 4; i++) mq[i] = bq[i];
    p = 0;
    do begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && mq[(p + k) % 4].size() > 0) begin
          found = 1;
          ex.push_back(8'hF0 + 8'((p + k) % 4));
          do begin w = mq[(p + k) % 4].pop_front(); ex.push_back(w[7:0]); end while (!w[8]);
          p = (p + k + 1) % 4;
        end
      end
    end while (found);
    en = 4'hF; gap_pct = 20; full_rand = 1;
    cyc = 0;
    do begin
      step(); cyc++;
      tot = bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size();
    end while ((tot != 0 || busy) && cyc < 2000);
    n_checks++; if (cyc >= 2000) begin n_fail++; $display("FAIL rand_timeout got=%0d cycles exp<2000", cyc); end
    n_checks++; if (got.size() != ex.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), ex.size()); end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      n_checks++; if (got[k] !== ex[k]) begin n_fail++; $display("FAIL rand_stream k=%0d got=%h exp=%h", k, got[k], ex[k]); end
    end
    n_checks++; if (abort_cnt != 0 || ready_viol != 0) begin n_fail++; $display("FAIL rand_protocol got aborts=%0d ready_viol=%0d exp 0/0", abort_cnt, ready_viol); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0; req_last = 4'b0; req_data = 32'h0; fifo_full = 1'b0;
    b_valid = 4'b0; b_last = 4'b0; b_data = 32'h0; b_full = 1'b0;
    en = 4'b0; gap_prev = 4'b0; gap_pct = 0; full_rand = 0; full_from = 0; full_to = 0; idx = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_no_tag();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
